// File: rtl/fpro_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// fpro_bus_arbiter_if
//   FPro MMIO-style bus bundle: chip select, write/read strobes, address,
//   write data, read data and a one-cycle completion pulse.
//
//   master modport : drives cs/wr/rd/addr/wr_data, observes rd_data/ready
//   slave  modport : observes cs/wr/rd/addr/wr_data, drives rd_data/ready
//
//   The arbiter presents a slave modport to each bus master and a master
//   modport toward the shared MMIO slave.  The MMIO slave has fixed timing,
//   so nothing drives ready on that instance.
// ---------------------------------------------------------------------------
interface fpro_bus_arbiter_if #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
);
  logic              cs;
  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              ready;

  modport master (output cs, wr, rd, addr, wr_data, input rd_data, ready);
  modport slave  (input cs, wr, rd, addr, wr_data, output rd_data, ready);
endinterface

// File: rtl/fpro_bus_arbiter.sv
// ---------------------------------------------------------------------------
// fpro_bus_arbiter
//   Two-master arbiter in front of a single FPro MMIO slave.  Master 0 is the
//   MCS bridge, master 1 the hardware sequencer.  Every transaction takes
//   exactly three cycles: IDLE (arbitrate + register request), ISSUE (one
//   slave strobe cycle, read data captured at its end), DONE (one-cycle
//   ready pulse to the winner).
//
//   Ports
//     clk    : system clock, rising edge
//     reset  : synchronous, active-high
//     m0     : slave-side bus toward master 0
//     m1     : slave-side bus toward master 1
//     mmio   : master-side bus toward the shared MMIO slave (rd_data is
//              combinational from the slave)
//     grant  : index of the master owning the current / last transaction
//
//   Configuration
//     FPRO_ARB_FIXED_PRI_EN : when defined, master 0 always wins simultaneous
//     requests and no priority pointer exists.  Default build: round-robin
//     with a 1-bit pointer that flips to the master not just served.
// ---------------------------------------------------------------------------
module fpro_bus_arbiter #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  fpro_bus_arbiter_if.slave  m0,
  fpro_bus_arbiter_if.slave  m1,
  fpro_bus_arbiter_if.master mmio,
  output logic               grant
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t            state;
  state_t            state_nxt;

  logic              req0;
  logic              req1;
  logic              any_req;
  logic              win;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              op_wr_q;
  logic              grant_q;
  logic [DATA_W-1:0] rd_data0_q;
  logic [DATA_W-1:0] rd_data1_q;

  logic              issue_cs;
  logic              issue_wr;
  logic              issue_rd;
  logic              rdy0;
  logic              rdy1;

  // A chip select without a strobe is not a request.
  assign req0    = m0.cs & (m0.wr | m0.rd);
  assign req1    = m1.cs & (m1.wr | m1.rd);
  assign any_req = req0 | req1;

`ifdef FPRO_ARB_FIXED_PRI_EN
  // Master 0 wins whenever it asks; master 1 only when alone.
  assign win = ~req0;
`else
  logic ptr;
  // Pointer only matters on a tie; a lone requester always wins.
  assign win = (req0 & req1) ? ptr : req1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and bus strobes
  always_comb begin
    state_nxt = state;
    issue_cs  = 1'b0;
    issue_wr  = 1'b0;
    issue_rd  = 1'b0;
    rdy0      = 1'b0;
    rdy1      = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ISSUE;
      end
      ISSUE: begin
        issue_cs  = 1'b1;
        issue_wr  = op_wr_q;
        issue_rd  = ~op_wr_q;
        state_nxt = DONE;
      end
      DONE: begin
        rdy0      = ~grant_q;
        rdy1      = grant_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture in IDLE, read capture at end of ISSUE, pointer in DONE.
  // The slave only ever sees this registered copy, so masters changing
  // their inputs mid-flight cannot disturb the transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      wr_data_q  <= '0;
      op_wr_q    <= 1'b0;
      grant_q    <= 1'b0;
      rd_data0_q <= '0;
      rd_data1_q <= '0;
`ifndef FPRO_ARB_FIXED_PRI_EN
      ptr        <= 1'b0;
`endif
    end else begin
      if (state == IDLE && any_req) begin
        grant_q   <= win;
        addr_q    <= win ? m1.addr    : m0.addr;
        wr_data_q <= win ? m1.wr_data : m0.wr_data;
        // Write takes precedence when both strobes are high.
        op_wr_q   <= win ? m1.wr      : m0.wr;
      end
      if (state == ISSUE && !op_wr_q) begin
        if (grant_q) rd_data1_q <= mmio.rd_data;
        else         rd_data0_q <= mmio.rd_data;
      end
`ifndef FPRO_ARB_FIXED_PRI_EN
      if (state == DONE) ptr <= ~grant_q;
`endif
    end
  end

  assign mmio.cs      = issue_cs;
  assign mmio.wr      = issue_wr;
  assign mmio.rd      = issue_rd;
  assign mmio.addr    = addr_q;
  assign mmio.wr_data = wr_data_q;

  assign m0.ready     = rdy0;
  assign m1.ready     = rdy1;
  assign m0.rd_data   = rd_data0_q;
  assign m1.rd_data   = rd_data1_q;

  assign grant        = grant_q;

endmodule

// File: tb/tb_fpro_bus_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_fpro_bus_arbiter
//   Directed bench for fpro_bus_arbiter.  Inputs change and outputs are
//   observed on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_fpro_bus_arbiter;
  localparam int ADDR_W = 21;
  localparam int DATA_W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic grant;

  int pass_cnt  = 0;
  int total_cnt = 0;

  fpro_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_bus ();
  fpro_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_bus ();
  fpro_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mmio_bus ();

  fpro_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .mmio  (mmio_bus),
    .grant (grant)
  );

  always #5 clk = ~clk;

  task automatic drive_m0(input logic cs, input logic wr, input logic rd,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    m0_bus.cs = cs; m0_bus.wr = wr; m0_bus.rd = rd;
    m0_bus.addr = addr; m0_bus.wr_data = data;
  endtask

  task automatic drive_m1(input logic cs, input logic wr, input logic rd,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    m1_bus.cs = cs; m1_bus.wr = wr; m1_bus.rd = rd;
    m1_bus.addr = addr; m1_bus.wr_data = data;
  endtask

  task automatic test_reset();
    drive_m0(1'b0, 1'b0, 1'b0, '0, '0);
    drive_m1(1'b0, 1'b0, 1'b0, '0, '0);
    mmio_bus.rd_data = '0;
    mmio_bus.ready   = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (grant !== 1'b0) $display("FAIL rst_grant: got %b expected 0", grant); else pass_cnt++;
    total_cnt++; if (mmio_bus.cs !== 1'b0) $display("FAIL rst_cs: got %b expected 0", mmio_bus.cs); else pass_cnt++;
    total_cnt++; if (mmio_bus.wr !== 1'b0) $display("FAIL rst_wr: got %b expected 0", mmio_bus.wr); else pass_cnt++;
    total_cnt++; if (mmio_bus.rd !== 1'b0) $display("FAIL rst_rd: got %b expected 0", mmio_bus.rd); else pass_cnt++;
    total_cnt++; if (mmio_bus.addr !== 21'h0) $display("FAIL rst_addr: got %h expected 0", mmio_bus.addr); else pass_cnt++;
    total_cnt++; if (mmio_bus.wr_data !== 32'h0) $display("FAIL rst_wr_data: got %h expected 0", mmio_bus.wr_data); else pass_cnt++;
    total_cnt++; if (m0_bus.ready !== 1'b0) $display("FAIL rst_m0_ready: got %b expected 0", m0_bus.ready); else pass_cnt++;
    total_cnt++; if (m1_bus.ready !== 1'b0) $display("FAIL rst_m1_ready: got %b expected 0", m1_bus.ready); else pass_cnt++;
    total_cnt++; if (m0_bus.rd_data !== 32'h0) $display("FAIL rst_m0_rd_data: got %h expected 0", m0_bus.rd_data); else pass_cnt++;
    total_cnt++; if (m1_bus.rd_data !== 32'h0) $display("FAIL rst_m1_rd_data: got %h expected 0", m1_bus.rd_data); else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_m0_write();
    drive_m0(1'b1, 1'b1, 1'b0, 21'h00010, 32'h0000ABCD);
    @(negedge clk); // ISSUE
    total_cnt++; if (mmio_bus.cs !== 1'b1) $display("FAIL wr_issue_cs: got %b expected 1", mmio_bus.cs); else pass_cnt++;
    total_cnt++; if (mmio_bus.wr !== 1'b1) $display("FAIL wr_issue_wr: got %b expected 1", mmio_bus.wr); else pass_cnt++;
    total_cnt++; if (mmio_bus.rd !== 1'b0) $display("FAIL wr_issue_rd: got %b expected 0", mmio_bus.rd); else pass_cnt++;
    total_cnt++; if (mmio_bus.addr !== 21'h00010) $display("FAIL wr_issue_addr: got %h expected 00010", mmio_bus.addr); else pass_cnt++;
    total_cnt++; if (mmio_bus.wr_data !== 32'h0000ABCD) $display("FAIL wr_issue_data: got %h expected 0000abcd", mmio_bus.wr_data); else pass_cnt++;
    total_cnt++; if (grant !== 1'b0) $display("FAIL wr_grant: got %b expected 0", grant); else pass_cnt++;
    total_cnt++; if (m0_bus.ready !== 1'b0) $display("FAIL wr_early_ready: got %b expected 0", m0_bus.ready); else pass_cnt++;
    @(negedge clk); // DONE
    total_cnt++; if (m0_bus.ready !== 1'b1) $display("FAIL wr_m0_ready: got %b expected 1", m0_bus.ready); else pass_cnt++;
    total_cnt++; if (m1_bus.ready !== 1'b0) $display("FAIL wr_m1_ready: got %b expected 0", m1_bus.ready); else pass_cnt++;
    total_cnt++; if (mmio_bus.wr !== 1'b0) $display("FAIL wr_strobe_one_cycle: got %b expected 0", mmio_bus.wr); else pass_cnt++;
    total_cnt++; if (mmio_bus.cs !== 1'b0) $display("FAIL wr_done_cs: got %b expected 0", mmio_bus.cs); else pass_cnt++;
    drive_m0(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk); // IDLE
    total_cnt++; if (m0_bus.ready !== 1'b0) $display("FAIL wr_ready_pulse: got %b expected 0", m0_bus.ready); else pass_cnt++;
    total_cnt++; if (mmio_bus.addr !== 21'h00010) $display("FAIL wr_addr_hold: got %h expected 00010", mmio_bus.addr); else pass_cnt++;
  endtask

  task automatic test_m1_read();
    mmio_bus.rd_data = 32'hDEADBEEF;
    drive_m1(1'b1, 1'b0, 1'b1, 21'h00200, 32'h0);
    @(negedge clk); // ISSUE
    total_cnt++; if (mmio_bus.rd !== 1'b1) $display("FAIL rd_issue_rd: got %b expected 1", mmio_bus.rd); else pass_cnt++;
    total_cnt++; if (mmio_bus.wr !== 1'b0) $display("FAIL rd_issue_wr: got %b expected 0", mmio_bus.wr); else pass_cnt++;
    total_cnt++; if (mmio_bus.addr !== 21'h00200) $display("FAIL rd_issue_addr: got %h expected 00200", mmio_bus.addr); else pass_cnt++;
    total_cnt++; if (grant !== 1'b1) $display("FAIL rd_grant: got %b expected 1", grant); else pass_cnt++;
    @(negedge clk); // DONE
    total_cnt++; if (m1_bus.rd_data !== 32'hDEADBEEF) $display("FAIL rd_m1_data: got %h expected deadbeef", m1_bus.rd_data); else pass_cnt++;
    total_cnt++; if (m1_bus.ready !== 1'b1) $display("FAIL rd_m1_ready: got %b expected 1", m1_bus.ready); else pass_cnt++;
    total_cnt++; if (m0_bus.ready !== 1'b0) $display("FAIL rd_m0_ready: got %b expected 0", m0_bus.ready); else pass_cnt++;
    total_cnt++; if (m0_bus.rd_data !== 32'h0) $display("FAIL rd_m0_data: got %h expected 0", m0_bus.rd_data); else pass_cnt++;
    drive_m1(1'b0, 1'b0, 1'b0, '0, '0);
    mmio_bus.rd_data = '0;
    @(negedge clk);
  endtask

  task automatic test_read_hold();
    mmio_bus.rd_data = 32'h12345678;
    drive_m0(1'b1, 1'b0, 1'b1, 21'h00008, 32'h0);
    @(negedge clk); // ISSUE: master misbehaves, in-flight copy must not move
    drive_m0(1'b1, 1'b1, 1'b0, 21'h1FFFF, 32'hFFFFFFFF);
    total_cnt++; if (mmio_bus.addr !== 21'h00008) $display("FAIL hold_issue_addr: got %h expected 00008", mmio_bus.addr); else pass_cnt++;
    @(negedge clk); // DONE
    total_cnt++; if (m0_bus.rd_data !== 32'h12345678) $display("FAIL hold_m0_data: got %h expected 12345678", m0_bus.rd_data); else pass_cnt++;
    total_cnt++; if (mmio_bus.addr !== 21'h00008) $display("FAIL hold_done_addr: got %h expected 00008", mmio_bus.addr); else pass_cnt++;
    drive_m0(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    mmio_bus.rd_data = 32'hCAFEF00D;
    drive_m0(1'b1, 1'b1, 1'b0, 21'h0000C, 32'h00000055);
    @(negedge clk); // ISSUE
    total_cnt++; if (mmio_bus.wr !== 1'b1) $display("FAIL hold_wr_strobe: got %b expected 1", mmio_bus.wr); else pass_cnt++;
    @(negedge clk); // DONE
    total_cnt++; if (m0_bus.ready !== 1'b1) $display("FAIL hold_wr_ready: got %b expected 1", m0_bus.ready); else pass_cnt++;
    total_cnt++; if (m0_bus.rd_data !== 32'h12345678) $display("FAIL hold_after_wr_m0: got %h expected 12345678", m0_bus.rd_data); else pass_cnt++;
    total_cnt++; if (m1_bus.rd_data !== 32'hDEADBEEF) $display("FAIL hold_after_wr_m1: got %h expected deadbeef", m1_bus.rd_data); else pass_cnt++;
    drive_m0(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_cs_only();
    drive_m0(1'b1, 1'b0, 1'b0, 21'h00040, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total_cnt++; if (mmio_bus.cs !== 1'b0) $display("FAIL cs_only_cs[%0d]: got %b expected 0", i, mmio_bus.cs); else pass_cnt++;
      total_cnt++; if (m0_bus.ready !== 1'b0) $display("FAIL cs_only_ready[%0d]: got %b expected 0", i, m0_bus.ready); else pass_cnt++;
    end
    drive_m0(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_wr_rd_both();
    mmio_bus.rd_data = 32'hBAD0BAD0;
    drive_m0(1'b1, 1'b1, 1'b1, 21'h00004, 32'h00000077);
    @(negedge clk); // ISSUE
    total_cnt++; if (mmio_bus.wr !== 1'b1) $display("FAIL both_wr: got %b expected 1", mmio_bus.wr); else pass_cnt++;
    total_cnt++; if (mmio_bus.rd !== 1'b0) $display("FAIL both_rd: got %b expected 0", mmio_bus.rd); else pass_cnt++;
    total_cnt++; if (mmio_bus.addr !== 21'h00004) $display("FAIL both_addr: got %h expected 00004", mmio_bus.addr); else pass_cnt++;
    @(negedge clk); // DONE
    total_cnt++; if (mmio_bus.wr !== 1'b0) $display("FAIL both_wr_single: got %b expected 0", mmio_bus.wr); else pass_cnt++;
    total_cnt++; if (mmio_bus.rd !== 1'b0) $display("FAIL both_rd_done: got %b expected 0", mmio_bus.rd); else pass_cnt++;
    total_cnt++; if (m0_bus.rd_data !== 32'h12345678) $display("FAIL both_rd_data: got %h expected 12345678", m0_bus.rd_data); else pass_cnt++;
    drive_m0(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    mmio_bus.rd_data = 32'h0BADCAFE;
    drive_m0(1'b1, 1'b0, 1'b1, 21'h00014, 32'h0);
    @(negedge clk); // ISSUE
    total_cnt++; if (mmio_bus.rd !== 1'b1) $display("FAIL abort_issue_rd: got %b expected 1", mmio_bus.rd); else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    total_cnt++; if (mmio_bus.cs !== 1'b0) $display("FAIL abort_cs: got %b expected 0", mmio_bus.cs); else pass_cnt++;
    total_cnt++; if (m0_bus.ready !== 1'b0) $display("FAIL abort_ready: got %b expected 0", m0_bus.ready); else pass_cnt++;
    total_cnt++; if (m0_bus.rd_data !== 32'h0) $display("FAIL abort_rd_data: got %h expected 0", m0_bus.rd_data); else pass_cnt++;
    total_cnt++; if (mmio_bus.addr !== 21'h0) $display("FAIL abort_addr: got %h expected 0", mmio_bus.addr); else pass_cnt++;
    reset = 1'b0;
    drive_m0(1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++; if (m0_bus.ready !== 1'b0) $display("FAIL abort_late_ready[%0d]: got %b expected 0", i, m0_bus.ready); else pass_cnt++;
    end
  endtask

  task automatic test_round_robin();
    logic exp_grant [4];
    logic found;
`ifdef FPRO_ARB_FIXED_PRI_EN
    exp_grant = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_grant = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mmio_bus.rd_data = 32'hA5A55A5A;
    drive_m0(1'b1, 1'b1, 1'b0, 21'h00010, 32'h00001111);
    drive_m1(1'b1, 1'b0, 1'b1, 21'h00020, 32'h0);
    for (int i = 0; i < 5; i++) begin
      logic eg;
      eg = (i < 4) ? exp_grant[i] : 1'b1;
      found = 1'b0;
      for (int c = 0; c < 6 && !found; c++) begin
        @(negedge clk);
        if (mmio_bus.cs === 1'b1) found = 1'b1;
      end
      total_cnt++; if (!found) $display("FAIL rr_timeout[%0d]: got no strobe expected strobe within 6 cycles", i); else pass_cnt++;
      total_cnt++; if (grant !== eg) $display("FAIL rr_grant[%0d]: got %b expected %b", i, grant, eg); else pass_cnt++;
      total_cnt++; if (mmio_bus.wr !== ~eg) $display("FAIL rr_op[%0d]: got wr=%b expected %b", i, mmio_bus.wr, ~eg); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (m0_bus.ready !== ~eg) $display("FAIL rr_m0_ready[%0d]: got %b expected %b", i, m0_bus.ready, ~eg); else pass_cnt++;
      total_cnt++; if (m1_bus.ready !== eg) $display("FAIL rr_m1_ready[%0d]: got %b expected %b", i, m1_bus.ready, eg); else pass_cnt++;
      if (i == 3) drive_m0(1'b0, 1'b0, 1'b0, '0, '0);
    end
    total_cnt++; if (m1_bus.rd_data !== 32'hA5A55A5A) $display("FAIL rr_m1_rd_data: got %h expected a5a55a5a", m1_bus.rd_data); else pass_cnt++;
    drive_m1(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_m0_write();
    test_m1_read();
    test_read_hold();
    test_cs_only();
    test_wr_rd_both();
    test_reset_abort();
    test_round_robin();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
